// File: rtl/store_port_responder.sv
// Store-buffer D$ write-port endpoint: grants stores into a small write
// FIFO, merges same-word stores into the tail and drains to memory.
package store_port_pkg;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH = 44;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
    logic                          approx;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;
endpackage

module store_port_responder
  import store_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter bit MERGE_EN = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dcache_req_i_t req_port_i,
  output dcache_req_o_t req_port_o,
  output logic          mem_req_o,
  input  logic          mem_gnt_i,
  output logic [63:0]   mem_addr_o,
  output logic [63:0]   mem_wdata_o,
  output logic [7:0]    mem_be_o,
  output logic [1:0]    mem_size_o,
  output logic          mem_approx_o,
  output logic          idle_o,
  output logic          err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [60:0] addr_q [DEPTH];
  logic [63:0] data_q [DEPTH];
  logic [7:0]  be_q   [DEPTH];
  logic [1:0]  size_q [DEPTH];
  logic        apx_q  [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q, tail;
  logic [CW-1:0] cnt_q;
  logic          rvalid_q, err_q;

  logic [63:0] addr;
  logic        pop, hit, full, gnt, push, merge;
  logic [7:0]  mrg_be;
  logic [63:0] mrg_data;
  logic        multi;
  logic        unused_bits;

  assign addr = 64'({req_port_i.address_tag, req_port_i.address_index});
  assign tail = wr_ptr_q - PW'(1);
  assign pop  = (cnt_q != '0) && mem_gnt_i;
  assign full = (cnt_q == CW'(DEPTH));

  // cnt>1 keeps a merge off the head entry while it is being offered to memory
  assign hit = MERGE_EN && (cnt_q > CW'(1)) &&
               (addr[63:3] == addr_q[tail]) &&
               (req_port_i.approx == apx_q[tail]);

  assign gnt   = req_port_i.data_req && req_port_i.data_we && (hit || !full);
  assign push  = gnt && !hit;
  assign merge = gnt && hit;

  always_comb begin
    mrg_be   = be_q[tail] | req_port_i.data_be;
    mrg_data = data_q[tail];
    for (int b = 0; b < 8; b++) begin
      if (req_port_i.data_be[b]) begin
        mrg_data[8*b +: 8] = req_port_i.data_wdata[8*b +: 8];
      end
    end
    multi = (mrg_be & (mrg_be - 8'd1)) != 8'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
        size_q[i] <= '0;
        apx_q[i]  <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= gnt;
      if (req_port_i.data_req && !req_port_i.data_we) err_q <= 1'b1;
      if (push) begin
        addr_q[wr_ptr_q] <= addr[63:3];
        data_q[wr_ptr_q] <= req_port_i.data_wdata;
        be_q[wr_ptr_q]   <= req_port_i.data_be;
        size_q[wr_ptr_q] <= req_port_i.data_size;
        apx_q[wr_ptr_q]  <= req_port_i.approx;
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (merge) begin
        data_q[tail] <= mrg_data;
        be_q[tail]   <= mrg_be;
        if (multi) size_q[tail] <= 2'b11;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign req_port_o.data_gnt    = gnt;
  assign req_port_o.data_rvalid = rvalid_q;
  assign req_port_o.data_rdata  = '0;

  assign mem_req_o    = (cnt_q != '0);
  assign mem_addr_o   = {addr_q[rd_ptr_q], 3'b000};
  assign mem_wdata_o  = data_q[rd_ptr_q];
  assign mem_be_o     = be_q[rd_ptr_q];
  assign mem_size_o   = size_q[rd_ptr_q];
  assign mem_approx_o = apx_q[rd_ptr_q];
  assign idle_o       = (cnt_q == '0);
  assign err_o        = err_q;

  assign unused_bits = ^{req_port_i.kill_req, req_port_i.tag_valid, addr[2:0]};

`ifndef SYNTHESIS
  a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CW'(DEPTH));
  a_no_empty_pop: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt_q == '0) |-> !pop);
`endif
endmodule

// File: tb/tb_store_port_responder.sv
// Scoreboard bench for store_port_responder: directed stores, merges,
// fill/backpressure, read errors, wrap with random memory grants, reset.
module tb_store_port_responder;
  import store_port_pkg::*;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  be;
    logic [1:0]  sz;
    logic        ap;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  dcache_req_i_t req_i;
  dcache_req_o_t req_o;
  logic          mem_req_o;
  logic          mem_gnt_i = 1'b0;
  logic [63:0]   mem_addr_o, mem_wdata_o;
  logic [7:0]    mem_be_o;
  logic [1:0]    mem_size_o;
  logic          mem_approx_o, idle_o, err_o;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   gnt_cnt = 0;
  int   rv_cnt = 0;
  bit   rand_gnt = 1'b0;

  store_port_responder #(.DEPTH(4), .MERGE_EN(1'b1)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_port_i(req_i),
    .req_port_o(req_o),
    .mem_req_o(mem_req_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o),
    .mem_size_o(mem_size_o),
    .mem_approx_o(mem_approx_o),
    .idle_o(idle_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_gnt) mem_gnt_i = 1'($urandom_range(0, 1));
  endtask

  task automatic push_exp(input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] be, input logic [1:0] sz,
                          input logic ap);
    exp_t e;
    e.a = a; e.d = d; e.be = be; e.sz = sz; e.ap = ap;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] be, input logic [1:0] sz,
                       input logic ap, input logic we);
    req_i.address_index = a[11:0];
    req_i.address_tag   = a[55:12];
    req_i.data_wdata    = d;
    req_i.data_be       = be;
    req_i.data_size     = sz;
    req_i.approx        = ap;
    req_i.data_we       = we;
    req_i.data_req      = 1'b1;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] be, input logic [1:0] sz,
                       input logic ap, input bit pe, output int n);
    bit granted;
    granted = 1'b0;
    n = 0;
    drive(a, d, be, sz, ap, 1'b1);
    while (!granted && n < 50) begin
      @(negedge clk_i);
      if (req_o.data_gnt) granted = 1'b1;
      else begin n++; tick(); end
    end
    if (!granted) begin
      checks++; errors++;
      $display("FAIL store_timeout: addr %h never granted", a);
    end else if (pe) push_exp(a, d, be, sz, ap);
    tick();
    req_i.data_req = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 200) begin
      @(negedge clk_i);
      if (idle_o) break;
      k++;
      tick();
    end
    chk("drain_idle", 64'(idle_o), 64'd1);
    tick();
  endtask

  // Monitor: response and memory-side scoreboard
  initial begin
    logic gp;
    exp_t e;
    gp = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        gp = 1'b0;
        continue;
      end
      if (req_o.data_rvalid || gp)
        chk("rvalid", 64'(req_o.data_rvalid), 64'(gp));
      if (req_o.data_rvalid) begin
        rv_cnt++;
        chk("rdata", req_o.data_rdata, 64'd0);
      end
      if (req_o.data_gnt) gnt_cnt++;
      gp = req_o.data_gnt;
      if (mem_req_o && mem_gnt_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: got addr %h expected no request",
                   mem_addr_o);
        end else begin
          e = exp_q.pop_front();
          chk("mem_addr", mem_addr_o, e.a);
          chk("mem_wdata", mem_wdata_o, e.d);
          chk("mem_be", 64'(mem_be_o), 64'(e.be));
          chk("mem_size", 64'(mem_size_o), 64'(e.sz));
          chk("mem_approx", 64'(mem_approx_o), 64'(e.ap));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g0, r0;
    req_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_gnt", 64'(req_o.data_gnt), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rvalid", 64'(req_o.data_rvalid), 64'd0);
    chk("rst_mem_addr", mem_addr_o, 64'd0);
    tick();

    // single store drains immediately
    mem_gnt_i = 1'b1;
    store(64'h1008, 64'hAABB, 8'h03, 2'b01, 1'b0, 1'b1, n);
    chk("single_gnt_latency", 64'(n), 64'd0);
    wait_idle();

    // merge into tail while memory is stalled
    mem_gnt_i = 1'b0;
    push_exp(64'h2000, 64'h11, 8'h01, 2'b00, 1'b0);
    push_exp(64'h2008, 64'h2211, 8'h03, 2'b11, 1'b0);
    store(64'h2000, 64'h11, 8'h01, 2'b00, 1'b0, 1'b0, n);
    store(64'h2008, 64'h11, 8'h01, 2'b00, 1'b0, 1'b0, n);
    store(64'h2008, 64'h2200, 8'h02, 2'b00, 1'b0, 1'b0, n);
    chk("merge_gnt_latency", 64'(n), 64'd0);
    @(negedge clk_i);
    chk("merge_not_idle", 64'(idle_o), 64'd0);
    chk("merge_head_addr", mem_addr_o, 64'h2000);
    tick();
    mem_gnt_i = 1'b1;
    wait_idle();

    // fill to DEPTH, fifth store held until a slot frees
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(64'h3000 + 64'(8 * i), 64'hF00 + 64'(i), 8'hFF, 2'b11,
            1'b0, 1'b1, n);
      chk("fill_gnt_latency", 64'(n), 64'd0);
    end
    push_exp(64'h3020, 64'hF04, 8'hFF, 2'b11, 1'b0);
    drive(64'h3020, 64'hF04, 8'hFF, 2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("full_hold", 64'(req_o.data_gnt), 64'd0);
      tick();
    end
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("no_full_bypass", 64'(req_o.data_gnt), 64'd0);
    tick();
    @(negedge clk_i);
    chk("gnt_after_pop", 64'(req_o.data_gnt), 64'd1);
    tick();
    req_i.data_req = 1'b0;
    wait_idle();

    // wrap with random memory grants
    g0 = gnt_cnt;
    r0 = rv_cnt;
    rand_gnt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      store(64'h4000 + 64'(8 * i), {32'hC0DE0000, 32'(i)}, 8'hFF, 2'b11,
            1'(i), 1'b1, n);
    end
    rand_gnt = 1'b0;
    mem_gnt_i = 1'b1;
    wait_idle();
    chk("wrap_gnt_count", 64'(gnt_cnt - g0), 64'd12);
    chk("wrap_rvalid_count", 64'(rv_cnt - r0), 64'd12);
    chk("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

    // read request: never granted, sticky error
    drive(64'h5000, 64'h0, 8'hFF, 2'b11, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("read_gnt", 64'(req_o.data_gnt), 64'd0);
    chk("read_err_before", 64'(err_o), 64'd0);
    tick();
    req_i.data_req = 1'b0;
    @(negedge clk_i);
    chk("read_err_next", 64'(err_o), 64'd1);
    repeat (10) tick();
    @(negedge clk_i);
    chk("read_err_sticky", 64'(err_o), 64'd1);
    tick();

    // reset mid-operation discards queued stores
    mem_gnt_i = 1'b0;
    store(64'h6000, 64'h1, 8'h01, 2'b00, 1'b0, 1'b0, n);
    store(64'h6008, 64'h2, 8'h01, 2'b00, 1'b0, 1'b0, n);
    rst_ni = 1'b0;
    tick();
    tick();
    mem_gnt_i = 1'b1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("post_rst_idle", 64'(idle_o), 64'd1);
    chk("post_rst_err", 64'(err_o), 64'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
